// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the MIPS write-back stage.
//   REG_DST_*  : destination-register select codes (wb_reg_dst)
//   REG_SRC_*  : write-data select codes (wb_reg_src)
//   REG_RA     : link register index used by JAL-class instructions
package wb_pkg;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_RA  = 2'b10;
  localparam logic [1:0] REG_DST_RSV = 2'b11;

  localparam logic [1:0] REG_SRC_ALU = 2'b00;
  localparam logic [1:0] REG_SRC_DM  = 2'b01;
  localparam logic [1:0] REG_SRC_PC4 = 2'b10;
  localparam logic [1:0] REG_SRC_RSV = 2'b11;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bundles the MEM/WB pipeline inputs, the two ID-stage read
// ports, the EX forwarding tap and the retired-instruction count.
//   master : pipeline side (drives MEM/WB fields and read indices)
//   slave  : write-back stage / register file
interface wb_regfile_if;

  logic [31:0] wb_alu_result;
  logic [31:0] wb_dm_out;
  logic [1:0]  wb_reg_src;
  logic [4:0]  wb_rt;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_reg_dst;
  logic        wb_reg_write;
  logic [31:0] wb_pc;

  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;

  logic [31:0] retired;

  modport master (
    output wb_alu_result, wb_dm_out, wb_reg_src, wb_rt, wb_rd,
           wb_reg_dst, wb_reg_write, wb_pc, rs_addr, rt_addr,
    input  rs_data, rt_data, fwd_valid, fwd_reg, fwd_data, retired
  );

  modport slave (
    input  wb_alu_result, wb_dm_out, wb_reg_src, wb_rt, wb_rd,
           wb_reg_dst, wb_reg_write, wb_pc, rs_addr, rt_addr,
    output rs_data, rt_data, fwd_valid, fwd_reg, fwd_data, retired
  );

endinterface

// File: rtl/wb_regfile_reg_array.sv
// reg_array: storage for architectural registers $1..$31 (32 bits each).
//   clk, rst          : clock, synchronous active-high clear of all entries
//   we, waddr, wdata  : single write port, committed on rising edge
//   raddr_a/rdata_a   : asynchronous read port A ($0 reads 0)
//   raddr_b/rdata_b   : asynchronous read port B ($0 reads 0)
module reg_array (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b
);

  // $0 is hardwired, so no storage is allocated for it.
  logic [31:0] mem [1:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < 32; i++) begin
        mem[5'(i)] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != 5'd0) rdata_a = mem[raddr_a];
    if (raddr_b != 5'd0) rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage plus 32x32 architectural register file.
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset (clears registers and counter)
//   bus  : wb_regfile_if.slave
//          MEM/WB inputs  wb_alu_result, wb_dm_out, wb_reg_src, wb_rt, wb_rd,
//                         wb_reg_dst, wb_reg_write, wb_pc (0 = bubble)
//          read ports     rs_addr/rs_data, rt_addr/rt_data (write-first bypass)
//          forward tap    fwd_valid, fwd_reg, fwd_data
//          retired        registered count of non-bubble instructions
module wb_regfile (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  import wb_pkg::*;

  logic [4:0]  dest;
  logic        dst_ok;
  logic [31:0] wr_data;
  logic        src_ok;
  logic        we;
  logic [31:0] arr_a;
  logic [31:0] arr_b;
  logic [31:0] retired_q;

  always_comb begin
    dest   = '0;
    dst_ok = 1'b1;
    case (bus.wb_reg_dst)
      REG_DST_RT: dest = bus.wb_rt;
      REG_DST_RD: dest = bus.wb_rd;
      REG_DST_RA: dest = REG_RA;
      default:    dst_ok = 1'b0;
    endcase
  end

  always_comb begin
    wr_data = '0;
    src_ok  = 1'b1;
    case (bus.wb_reg_src)
      REG_SRC_ALU: wr_data = bus.wb_alu_result;
      REG_SRC_DM:  wr_data = bus.wb_dm_out;
      REG_SRC_PC4: wr_data = bus.wb_pc + 32'd4;
      default:     src_ok = 1'b0;
    endcase
  end

  // Gating with rst here also disables bypass and forwarding during reset.
  assign we = bus.wb_reg_write & dst_ok & src_ok & (dest != 5'd0) & ~rst;

  reg_array u_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (dest),
    .wdata   (wr_data),
    .raddr_a (bus.rs_addr),
    .rdata_a (arr_a),
    .raddr_b (bus.rt_addr),
    .rdata_b (arr_b)
  );

  // Reads are forced to 0 under reset so the first reset cycle, before the
  // array has been cleared, already presents a clean register file.
  always_comb begin
    bus.rs_data = '0;
    bus.rt_data = '0;
    if (!rst) begin
      if (bus.rs_addr == 5'd0)                bus.rs_data = '0;
      else if (we && (bus.rs_addr == dest))   bus.rs_data = wr_data;
      else                                    bus.rs_data = arr_a;

      if (bus.rt_addr == 5'd0)                bus.rt_data = '0;
      else if (we && (bus.rt_addr == dest))   bus.rt_data = wr_data;
      else                                    bus.rt_data = arr_b;
    end
  end

  assign bus.fwd_valid = we;
  assign bus.fwd_reg   = we ? dest    : '0;
  assign bus.fwd_data  = we ? wr_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (bus.wb_pc != 32'd0) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.retired = retired_q;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the pipelined MIPS core. Consumes the MEM/WB pipeline register outputs, selects destination register and write data, and commits them to a 32×32-bit register file on the rising clock edge. Provides the two ID-stage read ports with same-cycle write bypass, a forwarding tap for the EX-stage forwarding unit, and a retired-instruction counter.

## Interface
- No parameters; widths fixed (32-bit data, 5-bit register index).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_alu_result  in  32  ALU result from MEM/WB.
- wb_dm_out  in  32  data-memory read data from MEM/WB.
- wb_reg_src  in  2  write-data select (encoding below).
- wb_rt  in  5  instruction rt field.
- wb_rd  in  5  instruction rd field.
- wb_reg_dst  in  2  destination select (encoding below).
- wb_reg_write  in  1  register write enable.
- wb_pc  in  32  instruction PC; 0 marks a bubble.
- rs_addr  in  5  read port A index.
- rt_addr  in  5  read port B index.
- rs_data  out  32  read port A data.
- rt_data  out  32  read port B data.
- fwd_valid  out  1  a non-$0 write commits this cycle.
- fwd_reg  out  5  destination index of that write.
- fwd_data  out  32  data of that write.
- retired  out  32  count of non-bubble instructions passed through WB.

## Operation
- Destination: reg_dst 00 → rt, 01 → rd, 10 → 31 ($ra), 11 → reserved, write suppressed.
- Write data: reg_src 00 → alu_result, 01 → dm_out, 10 → pc + 4 (32-bit, wraps), 11 → reserved, write suppressed.
- Effective write we = wb_reg_write & legal reg_dst & legal reg_src & (dest ≠ 0).
- On rising edge with we: regs[dest] ← data. $0 never written; always reads 0.
- Read ports combinational: index 0 → 0; index == dest with we → current write data (write-first bypass); else regs[index].
- fwd_valid = we; fwd_reg = dest, fwd_data = data when we, both 0 otherwise.
- retired increments by 1 on each edge where wb_pc ≠ 0; wraps 0xFFFFFFFF → 0. Counts independent of we (stores/branches retire too).

## Timing
- Reset (rst high at rising edge): all 31 registers ← 0, retired ← 0. Register writes and counter increment suppressed in that cycle even if we asserted. With rst held, rs_data/rt_data read 0 except through bypass, which is also gated off by rst; fwd_valid = 0.
- Write latency: data visible on read ports same cycle via bypass, from the register array on the next cycle.
- Simultaneous: both read ports may hit the write destination; both bypass. rs_addr == rt_addr legal.
- Back-to-back writes to the same register: last one wins, each visible in its own cycle.
- retired reflects increments of previous edges only (registered output).

## Structure
- Package wb_pkg: REG_DST_RT/RD/RA/RSV and REG_SRC_ALU/DM/PC4/RSV localparams, REG_RA = 5'd31.
- Sub-module reg_array: 31×32 storage, one write port, two async read ports, synchronous clear. Muxing, bypass, forwarding and counter live in wb_regfile.

## Test plan
- Reset: write 0x1234 to $5, assert rst one cycle → reading $5 gives 0, retired = 0.
- ALU write: reg_dst=01, rd=8, reg_src=00, alu=0xDEADBEEF, reg_write=1 → rs_addr=8 reads 0xDEADBEEF same cycle (bypass) and next cycle; fwd_valid=1, fwd_reg=8.
- JAL: reg_dst=10, reg_src=10, pc=0x00400010 → $31 = 0x00400014; pc=0xFFFFFFFC → $31 = 0.
- $0 protection: reg_dst=00, rt=0, alu=0xFFFFFFFF, reg_write=1 → $0 reads 0, fwd_valid=0.
- Reserved encodings: reg_dst=11 or reg_src=11 with reg_write=1 → no register changes, fwd_valid=0, retired still increments if pc≠0.
- Counter: 5 cycles pc≠0 interleaved with 3 bubbles (pc=0) → retired = 5; preload via 2^32−1 increments (or forced) → wraps to 0.
